// File: rtl/rs_adder_station.sv
// Reservation station for the integer adder functional units.
// Holds issued add/sub ops until both operands are known (either at issue or
// by snooping the CDB), then dispatches them to the adder and waits for the
// adder's result to come back on the CDB before freeing the entry.
// Optional feature: define RS_AGE_ORDER_EN for oldest-first dispatch selection
// (2-bit saturating age per entry); otherwise lowest-index READY entry wins.
module rs_adder_station #(
    parameter int unsigned NUM_ENTRIES = 3,
    parameter int unsigned TAG_BASE    = 1,
    parameter int unsigned TAG_W       = 4,
    parameter int unsigned DATA_W      = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    // Issue interface
    input  logic              i_issue_valid,
    input  logic              i_issue_op,
    input  logic [DATA_W-1:0] i_issue_vj,
    input  logic [TAG_W-1:0]  i_issue_qj,
    input  logic [DATA_W-1:0] i_issue_vk,
    input  logic [TAG_W-1:0]  i_issue_qk,
    output logic              o_issue_ready,
    output logic [TAG_W-1:0]  o_issue_tag,
    // CDB snoop
    input  logic [DATA_W-1:0] i_cdb_data,
    input  logic [TAG_W-1:0]  i_cdb_tag,
    input  logic              i_cdb_valid,
    // Dispatch to adder
    output logic              o_disp_valid,
    input  logic              i_disp_ready,
    output logic              o_disp_op,
    output logic [DATA_W-1:0] o_disp_vj,
    output logic [DATA_W-1:0] o_disp_vk,
    output logic [TAG_W-1:0]  o_disp_tag
);

    localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    typedef enum logic [1:0] {
        StFree  = 2'd0,
        StWait  = 2'd1,
        StReady = 2'd2,
        StExec  = 2'd3
    } state_e;

    // Entry i owns tag TAG_BASE + i.
    function automatic logic [TAG_W-1:0] f_tag(input int idx);
        return TAG_W'(TAG_BASE + idx);
    endfunction

    // Entry array
    state_e            r_state [NUM_ENTRIES];
    logic              r_op    [NUM_ENTRIES];
    logic [DATA_W-1:0] r_vj    [NUM_ENTRIES];
    logic [DATA_W-1:0] r_vk    [NUM_ENTRIES];
    logic [TAG_W-1:0]  r_qj    [NUM_ENTRIES];
    logic [TAG_W-1:0]  r_qk    [NUM_ENTRIES];
`ifdef RS_AGE_ORDER_EN
    logic [1:0]        r_age   [NUM_ENTRIES];
    // Saturated ages can tie, so the stalled selection is pinned explicitly.
    logic              r_hold;
    logic [IDX_W-1:0]  r_hold_idx;
    logic [1:0]        w_best_age;
`endif

    logic              w_free_any;
    logic [IDX_W-1:0]  w_alloc_idx;
    logic              w_issue_fire;
    logic              w_byp_j;
    logic              w_byp_k;
    logic [TAG_W-1:0]  w_new_qj;
    logic [TAG_W-1:0]  w_new_qk;
    logic [DATA_W-1:0] w_new_vj;
    logic [DATA_W-1:0] w_new_vk;
    logic [NUM_ENTRIES-1:0] w_hit_j;
    logic [NUM_ENTRIES-1:0] w_hit_k;
    logic              w_disp_any;
    logic [IDX_W-1:0]  w_sel_idx;
    logic              w_disp_fire;

    // Allocation: lowest-index FREE entry, from registered state only.
    always_comb begin
        w_free_any  = 1'b0;
        w_alloc_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (r_state[i] == StFree) begin
                w_free_any  = 1'b1;
                w_alloc_idx = IDX_W'(i);
            end
        end
    end

    // Issue-time bypass and CDB operand match per entry.
    always_comb begin
        w_issue_fire = i_issue_valid && w_free_any;
        w_byp_j  = i_cdb_valid && (i_issue_qj != '0) && (i_issue_qj == i_cdb_tag);
        w_byp_k  = i_cdb_valid && (i_issue_qk != '0) && (i_issue_qk == i_cdb_tag);
        w_new_qj = w_byp_j ? '0 : i_issue_qj;
        w_new_qk = w_byp_k ? '0 : i_issue_qk;
        w_new_vj = w_byp_j ? i_cdb_data : i_issue_vj;
        w_new_vk = w_byp_k ? i_cdb_data : i_issue_vk;
        w_hit_j  = '0;
        w_hit_k  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_hit_j[i] = i_cdb_valid && (r_state[i] == StWait) && (r_qj[i] != '0) &&
                         (r_qj[i] == i_cdb_tag);
            w_hit_k[i] = i_cdb_valid && (r_state[i] == StWait) && (r_qk[i] != '0) &&
                         (r_qk[i] == i_cdb_tag);
        end
    end

    // Dispatch selection among READY entries.
    always_comb begin
        w_disp_any = 1'b0;
        w_sel_idx  = '0;
`ifdef RS_AGE_ORDER_EN
        w_best_age = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            // Strict compare keeps the lower index on ties.
            if (r_state[i] == StReady && (!w_disp_any || r_age[i] > w_best_age)) begin
                w_disp_any = 1'b1;
                w_sel_idx  = IDX_W'(i);
                w_best_age = r_age[i];
            end
        end
        if (r_hold) begin
            w_sel_idx = r_hold_idx;
        end
`else
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (r_state[i] == StReady && !w_disp_any) begin
                w_disp_any = 1'b1;
                w_sel_idx  = IDX_W'(i);
            end
        end
`endif
        w_disp_fire = w_disp_any && i_disp_ready;
    end

    // Outputs, combinational from the entry array.
    always_comb begin
        o_issue_ready = w_free_any;
        o_issue_tag   = f_tag(32'(w_alloc_idx));
        o_disp_valid  = w_disp_any;
        o_disp_op     = 1'b0;
        o_disp_vj     = '0;
        o_disp_vk     = '0;
        o_disp_tag    = '0;
        if (w_disp_any) begin
            o_disp_op  = r_op[w_sel_idx];
            o_disp_vj  = r_vj[w_sel_idx];
            o_disp_vk  = r_vk[w_sel_idx];
            o_disp_tag = f_tag(32'(w_sel_idx));
        end
    end

    // Per-entry FSM and operand storage.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_state[i] <= StFree;
                r_op[i]    <= 1'b0;
                r_vj[i]    <= '0;
                r_vk[i]    <= '0;
                r_qj[i]    <= '0;
                r_qk[i]    <= '0;
`ifdef RS_AGE_ORDER_EN
                r_age[i]   <= '0;
`endif
            end
`ifdef RS_AGE_ORDER_EN
            r_hold     <= 1'b0;
            r_hold_idx <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                unique case (r_state[i])
                    StFree: begin
                        if (w_issue_fire && w_alloc_idx == IDX_W'(i)) begin
                            r_op[i]    <= i_issue_op;
                            r_vj[i]    <= w_new_vj;
                            r_vk[i]    <= w_new_vk;
                            r_qj[i]    <= w_new_qj;
                            r_qk[i]    <= w_new_qk;
                            r_state[i] <= (w_new_qj != '0 || w_new_qk != '0) ? StWait : StReady;
                        end
                    end
                    StWait: begin
                        if (w_hit_j[i]) begin
                            r_vj[i] <= i_cdb_data;
                            r_qj[i] <= '0;
                        end
                        if (w_hit_k[i]) begin
                            r_vk[i] <= i_cdb_data;
                            r_qk[i] <= '0;
                        end
                        if ((r_qj[i] == '0 || w_hit_j[i]) && (r_qk[i] == '0 || w_hit_k[i])) begin
                            r_state[i] <= StReady;
                        end
                    end
                    StReady: begin
                        if (w_disp_fire && w_sel_idx == IDX_W'(i)) begin
                            r_state[i] <= StExec;
                        end
                    end
                    StExec: begin
                        if (i_cdb_valid && i_cdb_tag == f_tag(i)) begin
                            r_state[i] <= StFree;
                        end
                    end
                    default: r_state[i] <= StFree;
                endcase
`ifdef RS_AGE_ORDER_EN
                if (w_issue_fire) begin
                    if (w_alloc_idx == IDX_W'(i)) begin
                        r_age[i] <= '0;
                    end else if (r_state[i] != StFree && r_age[i] != 2'd3) begin
                        r_age[i] <= r_age[i] + 2'd1;
                    end
                end
`endif
            end
`ifdef RS_AGE_ORDER_EN
            r_hold     <= w_disp_any && !i_disp_ready;
            r_hold_idx <= w_sel_idx;
`endif
        end
    end

endmodule
